// File: rtl/seq_check_sched.sv
// Round-robin arbiter sharing one "sig ##1 sig ... (REPEAT high samples)" checker
// between NREQ requesters, with saturating pass/fail statistics.
module seq_check_sched #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned REPEAT = 2,
   parameter int unsigned CNTW   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         sig,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [$clog2(NREQ)-1:0] done_id,
   output logic [CNTW-1:0]         pass_cnt,
   output logic [CNTW-1:0]         fail_cnt
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(REPEAT + 1);

   typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  cur_q, cur_d;
   logic [IDW-1:0]  last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [IDW-1:0]  done_id_q, done_id_d;
   logic [CNTW-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNTW-1:0] fail_cnt_q, fail_cnt_d;
   logic [IDW-1:0]  pick;
   logic            found;

   // First requester found scanning upward from last_q+1, wrapping modulo NREQ.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!found && req[IDW'((32'(last_q) + i) % NREQ)]) begin
            pick  = IDW'((32'(last_q) + i) % NREQ);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      done_id_d  = done_id_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;

      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               cur_d   = pick;
               cnt_d   = '0;
               gnt_d   = NREQ'(1) << pick;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!sig[cur_q]) begin
               done_d    = 1'b1;
               pass_d    = 1'b0;
               done_id_d = cur_q;
               state_d   = REPORT;
            end else if (cnt_q == CW'(REPEAT - 1)) begin
               done_d    = 1'b1;
               pass_d    = 1'b1;
               done_id_d = cur_q;
               state_d   = REPORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPORT: begin
            // pass_q still holds this check's result during the REPORT cycle.
            if (pass_q) begin
               if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
               if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
            end
            last_d  = cur_q;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         last_q     <= IDW'(NREQ - 1);
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         done_id_q  <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         done_id_q  <= done_id_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign pass     = pass_q;
   assign done_id  = done_id_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_seq_check_sched.sv
// Bench for seq_check_sched: directed vector table, reset-abort sequence,
// randomized transactions against a transaction-level model, counter saturation.
module tb_seq_check_sched;

   localparam int REPEAT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, sig, gnt;
   logic       busy, done, pass;
   logic [1:0] done_id;
   logic [15:0] pass_cnt, fail_cnt;

   logic [3:0] s_req, s_sig, s_gnt;
   logic       s_busy, s_done, s_pass;
   logic [1:0] s_done_id;
   logic [1:0] s_pass_cnt, s_fail_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int pm, fm, last_m;

   always #5 clk = ~clk;

   seq_check_sched #(.NREQ(4), .REPEAT(REPEAT), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .req(req), .sig(sig), .gnt(gnt), .busy(busy),
      .done(done), .pass(pass), .done_id(done_id),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   seq_check_sched #(.NREQ(4), .REPEAT(REPEAT), .CNTW(2)) u_sat (
      .clk(clk), .rst(rst), .req(s_req), .sig(s_sig), .gnt(s_gnt), .busy(s_busy),
      .done(s_done), .pass(s_pass), .done_id(s_done_id),
      .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
   );

   typedef struct {
      logic [3:0] r;
      logic [3:0] r_mid;
      int         fail_at;   // 0 = all samples high
      int         exp_id;
      logic       exp_pass;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int winner(input logic [3:0] r, input int last);
      int idx;
      for (int k = 1; k <= 4; k++) begin
         idx = (last + k) % 4;
         if (((r >> idx) & 4'd1) != 4'd0) return idx;
      end
      return -1;
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // One full transaction starting at the negedge of an IDLE cycle.
   task automatic txn(input logic [3:0] r, input logic [3:0] r_mid, input int fail_at,
                      input int exp_id, input logic exp_pass, input logic noisy);
      int n;
      logic [3:0] s, oh;
      oh  = 4'b1 << exp_id;
      n   = (fail_at == 0) ? REPEAT : fail_at;
      req = r;
      sig = noisy ? 4'($urandom) : 4'b0000;
      tick();
      chk("grant", 32'(gnt), 32'(oh));
      chk("busy_check", 32'(busy), 1);
      req = r_mid;
      for (int j = 1; j <= n; j++) begin
         s = noisy ? 4'($urandom) : 4'b1111;
         if (j == fail_at) s = s & ~oh;
         else              s = s | oh;
         sig = s;
         tick();
         if (j < n) begin
            chk("no_early_done", 32'(done), 0);
            chk("gnt_hold", 32'(gnt), 32'(oh));
         end
      end
      chk("done", 32'(done), 1);
      chk("pass", 32'(pass), 32'(exp_pass));
      chk("done_id", 32'(done_id), 32'(exp_id));
      chk("gnt_report", 32'(gnt), 32'(oh));
      if (exp_pass) pm = sat16(pm + 1);
      else          fm = sat16(fm + 1);
      last_m = exp_id;
      tick();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("pass_cnt", 32'(pass_cnt), 32'(pm));
      chk("fail_cnt", 32'(fail_cnt), 32'(fm));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int got, id, fa;
      logic [3:0] r;

      // 8 round-robin checks from reset, then single-requester pass/fail, then wrap.
      for (int k = 0; k < 8; k++) tbl[k] = '{4'b1111, 4'b1111, 0, k % 4, 1'b1};
      tbl[8]  = '{4'b0001, 4'b0001, 0, 0, 1'b1};
      tbl[9]  = '{4'b0010, 4'b0010, 2, 1, 1'b0};
      tbl[10] = '{4'b0010, 4'b0010, 1, 1, 1'b0};
      tbl[11] = '{4'b1010, 4'b1010, 0, 3, 1'b1};
      tbl[12] = '{4'b1010, 4'b1010, 0, 1, 1'b1};
      tbl[13] = '{4'b1010, 4'b0010, 0, 3, 1'b1};

      rst = 1'b1; req = '0; sig = '0; s_req = '0; s_sig = '0;
      pm = 0; fm = 0; last_m = 3;
      tick(); tick();
      rst = 1'b0;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_done_id", 32'(done_id), 0);
      chk("rst_pass_cnt", 32'(pass_cnt), 0);
      chk("rst_fail_cnt", 32'(fail_cnt), 0);

      foreach (tbl[i])
         txn(tbl[i].r, tbl[i].r_mid, tbl[i].fail_at, tbl[i].exp_id, tbl[i].exp_pass, 1'b0);

      // Reset while the final sample is pending: no done pulse, everything cleared.
      req = 4'b0001; sig = 4'b1111;
      tick();
      chk("abort_gnt", 32'(gnt), 1);
      tick();
      chk("abort_cnt1_done", 32'(done), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0; req = '0;
      chk("abort_gnt0", 32'(gnt), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_pass_cnt", 32'(pass_cnt), 0);
      chk("abort_fail_cnt", 32'(fail_cnt), 0);
      pm = 0; fm = 0; last_m = 3;
      txn(4'b1000, 4'b1000, 0, 3, 1'b1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         r  = 4'($urandom_range(1, 15));
         fa = int'($urandom_range(0, REPEAT));
         id = winner(r, last_m);
         txn(r, 4'($urandom), fa, id, fa == 0, 1'b1);
      end

      // Counter saturation on a 2-bit instance.
      s_req = 4'b0001; s_sig = 4'b1111;
      for (int n = 1; n <= 5; n++) begin
         got = 0;
         for (int c = 0; c < 8 && got == 0; c++) begin
            tick();
            if (s_done) got = 1;
         end
         chk("sat_done_seen", 32'(got), 1);
         chk("sat_pass", 32'(s_pass), 1);
         tick();
         chk("sat_pass_cnt", 32'(s_pass_cnt), (n > 3) ? 3 : n);
      end
      s_sig = 4'b0000;
      got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
         tick();
         if (s_done) got = 1;
      end
      chk("sat_fail_seen", 32'(got), 1);
      chk("sat_fail_pass", 32'(s_pass), 0);
      tick();
      s_req = '0;
      chk("sat_fail_cnt", 32'(s_fail_cnt), 1);
      chk("sat_pass_hold", 32'(s_pass_cnt), 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_check_sched.md
Name: seq_check_sched

Overview:
Round-robin scheduler that shares one sequence-check engine between NREQ requesters. Each requester raises a request together with its own sample signal. The engine checks that signal for the pattern "sig ##1 sig ... (REPEAT consecutive high samples)" and reports pass or fail with the requester id. Saturating pass and fail counters are kept for the regression harness, which uses the block to exercise sequence/property checking through a single shared resource.

Parameters:
NREQ, 4, number of requesters (2..16)
REPEAT, 2, consecutive high samples required for a pass (1..255)
CNTW, 16, width of the pass/fail statistics counters

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  reset, synchronous, active-high
req  input  NREQ  level request per requester
sig  input  NREQ  per-requester sample signal checked by the engine
gnt  output  NREQ  one-hot; requester currently owning the engine
busy  output  1  high while in CHECK or REPORT
done  output  1  one-cycle pulse when a check completes
pass  output  1  result qualifier, valid only while done=1
done_id  output  $clog2(NREQ)  id of the completed requester, valid while done=1
pass_cnt  output  CNTW  saturating count of passes
fail_cnt  output  CNTW  saturating count of fails

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; gnt=0, busy=0, done=0, pass=0, done_id=0, pass_cnt=0, fail_cnt=0.
  - Internal last-grant pointer = NREQ-1, so requester 0 has first priority.
  - rst mid-CHECK or mid-REPORT aborts the check. No done pulse; counters are cleared.
- States: IDLE, CHECK, REPORT.
- IDLE:
  - If req!=0, select the first set bit searching upward from last+1 with wrap modulo NREQ.
  - Latch it as cur; set gnt=onehot(cur) and cnt=0; go to CHECK next cycle.
  - If req==0, stay in IDLE; gnt=0.
- CHECK:
  - Each cycle sample sig[cur].
  - sig[cur]=0: result=fail; go to REPORT.
  - sig[cur]=1 and cnt==REPEAT-1: result=pass; go to REPORT.
  - Otherwise cnt<=cnt+1; stay in CHECK.
  - req[cur] deasserting during CHECK is ignored; the check runs to completion.
  - sig of non-granted requesters is ignored.
- REPORT (exactly one cycle):
  - done=1, pass=result, done_id=cur; gnt stays onehot(cur).
  - pass_cnt or fail_cnt increments by 1, saturating at all-ones.
  - last<=cur; next state is IDLE. gnt=0 in IDLE.
- Latency: req first seen in IDLE at cycle t means gnt from t+1, samples at t+1..t+REPEAT, and done at t+REPEAT+1 on a full pass. A fail at sample k (1-based) gives done at t+k+1.
- Back-to-back operation: one IDLE cycle between REPORT and the next CHECK. With all requests held high, grant order is 0,1,2,...,NREQ-1,0.
- Fairness: no requester waits more than NREQ-1 completed checks while its req is held.
- cnt width: $clog2(REPEAT+1). Counter saturation: at all-ones, further events of that kind leave the value unchanged.
- busy = (state!=IDLE).
- done, pass and done_id are registered outputs; no combinational path from req or sig to any output.

Test Plan:
1. Reset, then req=4'b0001 and sig[0] held 1 (REPEAT=2): gnt=0001 for 3 cycles, done at t+3 with pass=1, done_id=0; pass_cnt=1, fail_cnt=0.
2. req=4'b0010, sig[1]=1 then 0 on the second sample: done at t+3 with pass=0, done_id=1; fail_cnt=1. Repeat with sig[1]=0 on the first sample: done at t+2.
3. req=4'b1111 held, all sig=1, for 8 checks: done_id sequence 0,1,2,3,0,1,2,3; pass_cnt=8; exactly one IDLE cycle between each REPORT and the next gnt.
4. req=4'b1010 with last grant=1: next grant goes to 3, then 1, then 3 (wrap-around). Drop req[3] mid-CHECK: that check still completes with done_id=3.
5. Assert rst during CHECK (cnt=1): next cycle gnt=0, busy=0, no done pulse, counters=0. Then req=4'b1000 with last pointer=3: grant 3 (search starts at 0, only 3 set).
6. CNTW=2, 5 passing checks: pass_cnt reaches 3 and holds at 3. A fail then gives fail_cnt=1 with pass_cnt unchanged.
